// File: rtl/dram_request_arbiter.sv
// rtl/dram_request_arbiter.sv - round-robin DRAM read arbiter with owner-tracked return path and write pass-through
// Optional DRAM_ARB_FIXED_PRIORITY_EN: lowest-index pending reader wins instead of round-robin.
module dram_request_arbiter #(
  parameter int NUM_READERS      = 2,
  parameter int DRAM_ADDR_WIDTH  = 39,
  parameter int DRAM_DATA_WIDTH  = 128,
  parameter int OWNER_FIFO_DEPTH = 8
) (
  input  logic                                   clk_pixel,
  input  logic                                   dram_arbiter_reset,
  input  logic                                   dram_arbiter_flush,
  input  logic [NUM_READERS-1:0]                 rd_req_en,
  input  logic [NUM_READERS*DRAM_ADDR_WIDTH-1:0] rd_req_addr,
  input  logic [NUM_READERS*8-1:0]               rd_req_len,
  output logic [NUM_READERS-1:0]                 rd_req_busy,
  output logic [DRAM_DATA_WIDTH-1:0]             rd_data,
  output logic [NUM_READERS-1:0]                 rd_data_valid,
  input  logic                                   wr_req_en,
  input  logic [DRAM_ADDR_WIDTH-1:0]             wr_req_addr,
  input  logic [7:0]                             wr_req_len,
  input  logic [DRAM_DATA_WIDTH-1:0]             wr_req_data,
  output logic                                   wr_req_busy,
  output logic [DRAM_ADDR_WIDTH-1:0]             dram_read_addr,
  output logic [7:0]                             dram_read_len,
  output logic                                   dram_read_en,
  input  logic                                   dram_read_busy,
  input  logic [DRAM_DATA_WIDTH-1:0]             dram_read_data,
  input  logic                                   dram_read_data_valid,
  output logic [DRAM_ADDR_WIDTH-1:0]             dram_write_addr,
  output logic [7:0]                             dram_write_len,
  output logic                                   dram_write_en,
  output logic [DRAM_DATA_WIDTH-1:0]             dram_write_data,
  input  logic                                   dram_write_busy,
  output logic [1:0]                             err_flags
);

  localparam int IW  = (NUM_READERS > 1) ? $clog2(NUM_READERS) : 1;
  localparam int FAW = $clog2(OWNER_FIFO_DEPTH);
  localparam logic [FAW:0] FIFO_FULL_CNT = (FAW+1)'(OWNER_FIFO_DEPTH);

  typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_HOLD} state_t;

  state_t                       rd_state_q, rd_state_d, wr_state_q, wr_state_d;
  logic [NUM_READERS-1:0]       rd_pend_q, rd_pend_d;
  logic [DRAM_ADDR_WIDTH-1:0]   rd_addr_q [NUM_READERS];
  logic [DRAM_ADDR_WIDTH-1:0]   rd_addr_d [NUM_READERS];
  logic [7:0]                   rd_len_q  [NUM_READERS];
  logic [7:0]                   rd_len_d  [NUM_READERS];
  logic [IW-1:0]                rd_gnt_q, rd_gnt_d, rd_ptr_q, rd_ptr_d, gnt_idx;
  logic                         wr_pend_q, wr_pend_d;
  logic [DRAM_ADDR_WIDTH-1:0]   wr_addr_q, wr_addr_d;
  logic [7:0]                   wr_len_q, wr_len_d;
  logic [DRAM_DATA_WIDTH-1:0]   wr_data_q, wr_data_d;
  logic [1:0]                   err_q, err_d;

  logic [IW-1:0]                own_idx_mem [OWNER_FIFO_DEPTH];
  logic [7:0]                   own_len_mem [OWNER_FIFO_DEPTH];
  logic [FAW-1:0]               wptr_q, wptr_d, rptr_q, rptr_d;
  logic [FAW:0]                 cnt_q, cnt_d;
  logic [7:0]                   beat_q, beat_d;
  logic [DRAM_DATA_WIDTH-1:0]   rd_data_q, rd_data_d;
  logic [NUM_READERS-1:0]       rd_valid_q, rd_valid_d;
  logic                         own_push, own_pop, fifo_full, fifo_empty, orphan;
  logic [IW-1:0]                head_idx;
  logic [7:0]                   head_len;

  assign fifo_full  = (cnt_q == FIFO_FULL_CNT);
  assign fifo_empty = (cnt_q == '0);
  assign head_idx   = own_idx_mem[rptr_q];
  assign head_len   = own_len_mem[rptr_q];
  assign own_push   = (rd_state_q == ST_ISSUE);
  assign orphan     = dram_read_data_valid && fifo_empty;

  // Pending slots and sticky errors; flush is applied last so it overrides captures.
  always_comb begin
    rd_pend_d = rd_pend_q;
    rd_addr_d = rd_addr_q;
    rd_len_d  = rd_len_q;
    wr_pend_d = wr_pend_q;
    wr_addr_d = wr_addr_q;
    wr_len_d  = wr_len_q;
    wr_data_d = wr_data_q;
    err_d     = err_q;
    for (int i = 0; i < NUM_READERS; i++) begin
      if (rd_req_en[i]) begin
        if (rd_pend_q[i]) begin
          err_d[1] = 1'b1;
        end else if (rd_req_len[i*8 +: 8] != 8'd0) begin
          rd_pend_d[i] = 1'b1;
          rd_addr_d[i] = rd_req_addr[i*DRAM_ADDR_WIDTH +: DRAM_ADDR_WIDTH];
          rd_len_d[i]  = rd_req_len[i*8 +: 8];
        end
      end
    end
    if (wr_req_en) begin
      if (wr_pend_q) begin
        err_d[1] = 1'b1;
      end else if (wr_req_len != 8'd0) begin
        wr_pend_d = 1'b1;
        wr_addr_d = wr_req_addr;
        wr_len_d  = wr_req_len;
        wr_data_d = wr_req_data;
      end
    end
    if (rd_state_q == ST_ISSUE) rd_pend_d[rd_gnt_q] = 1'b0;
    if (wr_state_q == ST_ISSUE) wr_pend_d = 1'b0;
    if (dram_arbiter_flush) begin
      rd_pend_d = '0;
      wr_pend_d = 1'b0;
    end
    if (orphan) err_d[0] = 1'b1;
  end

  always_comb begin
    gnt_idx = '0;
`ifdef DRAM_ARB_FIXED_PRIORITY_EN
    for (int k = NUM_READERS - 1; k >= 0; k--) begin
      if (rd_pend_q[k]) gnt_idx = IW'(k);
    end
`else
    // Walk from the farthest candidate to the nearest so the first pending slot after the pointer wins.
    for (int k = NUM_READERS; k >= 1; k--) begin
      int idx;
      idx = (int'(rd_ptr_q) + k) % NUM_READERS;
      if (rd_pend_q[idx]) gnt_idx = IW'(idx);
    end
`endif
  end

  always_comb begin
    rd_state_d = rd_state_q;
    rd_gnt_d   = rd_gnt_q;
    rd_ptr_d   = rd_ptr_q;
    case (rd_state_q)
      ST_IDLE: begin
        if ((|rd_pend_q) && !dram_read_busy && !fifo_full && !dram_arbiter_flush) begin
          rd_state_d = ST_ISSUE;
          rd_gnt_d   = gnt_idx;
        end
      end
      ST_ISSUE: begin
        rd_ptr_d   = rd_gnt_q;
        rd_state_d = ST_HOLD;
      end
      default: rd_state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    wr_state_d = wr_state_q;
    case (wr_state_q)
      ST_IDLE:  if (wr_pend_q && !dram_write_busy && !dram_arbiter_flush) wr_state_d = ST_ISSUE;
      ST_ISSUE: wr_state_d = ST_HOLD;
      default:  wr_state_d = ST_IDLE;
    endcase
  end

  // Return path: beats are steered to the owner FIFO head; the last beat of a command pops it.
  always_comb begin
    beat_d     = beat_q;
    own_pop    = 1'b0;
    rd_valid_d = '0;
    rd_data_d  = rd_data_q;
    if (dram_read_data_valid && !fifo_empty) begin
      rd_data_d            = dram_read_data;
      rd_valid_d[head_idx] = 1'b1;
      if (beat_q + 8'd1 == head_len) begin
        own_pop = 1'b1;
        beat_d  = 8'd0;
      end else begin
        beat_d  = beat_q + 8'd1;
      end
    end
    wptr_d = own_push ? wptr_q + FAW'(1) : wptr_q;
    rptr_d = own_pop  ? rptr_q + FAW'(1) : rptr_q;
    cnt_d  = cnt_q + {{FAW{1'b0}}, own_push} - {{FAW{1'b0}}, own_pop};
  end

  always_ff @(posedge clk_pixel) begin
    if (own_push) begin
      own_idx_mem[wptr_q] <= rd_gnt_q;
      own_len_mem[wptr_q] <= rd_len_q[rd_gnt_q];
    end
  end

  always_ff @(posedge clk_pixel or posedge dram_arbiter_reset) begin
    if (dram_arbiter_reset) begin
      rd_state_q <= ST_IDLE;
      wr_state_q <= ST_IDLE;
      rd_pend_q  <= '0;
      for (int i = 0; i < NUM_READERS; i++) begin
        rd_addr_q[i] <= '0;
        rd_len_q[i]  <= '0;
      end
      rd_gnt_q   <= '0;
      rd_ptr_q   <= IW'(NUM_READERS - 1);
      wr_pend_q  <= 1'b0;
      wr_addr_q  <= '0;
      wr_len_q   <= '0;
      wr_data_q  <= '0;
      err_q      <= '0;
      wptr_q     <= '0;
      rptr_q     <= '0;
      cnt_q      <= '0;
      beat_q     <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= '0;
    end else begin
      rd_state_q <= rd_state_d;
      wr_state_q <= wr_state_d;
      rd_pend_q  <= rd_pend_d;
      rd_addr_q  <= rd_addr_d;
      rd_len_q   <= rd_len_d;
      rd_gnt_q   <= rd_gnt_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_pend_q  <= wr_pend_d;
      wr_addr_q  <= wr_addr_d;
      wr_len_q   <= wr_len_d;
      wr_data_q  <= wr_data_d;
      err_q      <= err_d;
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      cnt_q      <= cnt_d;
      beat_q     <= beat_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
    end
  end

  assign rd_req_busy     = rd_pend_q;
  assign wr_req_busy     = wr_pend_q;
  assign rd_data         = rd_data_q;
  assign rd_data_valid   = rd_valid_q;
  assign err_flags       = err_q;
  assign dram_read_en    = (rd_state_q == ST_ISSUE);
  assign dram_read_addr  = dram_read_en ? rd_addr_q[rd_gnt_q] : '0;
  assign dram_read_len   = dram_read_en ? rd_len_q[rd_gnt_q] : '0;
  assign dram_write_en   = (wr_state_q == ST_ISSUE);
  assign dram_write_addr = dram_write_en ? wr_addr_q : '0;
  assign dram_write_len  = dram_write_en ? wr_len_q : '0;
  assign dram_write_data = dram_write_en ? wr_data_q : '0;

endmodule

// File: tb/tb_dram_request_arbiter.sv
// tb/tb_dram_request_arbiter.sv - directed self-checking bench for dram_request_arbiter
module tb_dram_request_arbiter;

  logic         clk_pixel = 1'b0;
  logic         rst = 1'b1;
  logic         flush = 1'b0;
  logic [1:0]   rd_req_en = '0;
  logic [77:0]  rd_req_addr = '0;
  logic [15:0]  rd_req_len = '0;
  logic [1:0]   rd_req_busy;
  logic [127:0] rd_data;
  logic [1:0]   rd_data_valid;
  logic         wr_req_en = 1'b0;
  logic [38:0]  wr_req_addr = '0;
  logic [7:0]   wr_req_len = '0;
  logic [127:0] wr_req_data = '0;
  logic         wr_req_busy;
  logic [38:0]  dram_read_addr;
  logic [7:0]   dram_read_len;
  logic         dram_read_en;
  logic         dram_read_busy = 1'b0;
  logic [127:0] dram_read_data = '0;
  logic         dram_read_data_valid = 1'b0;
  logic [38:0]  dram_write_addr;
  logic [7:0]   dram_write_len;
  logic         dram_write_en;
  logic [127:0] dram_write_data;
  logic         dram_write_busy = 1'b0;
  logic [1:0]   err_flags;

  int total = 0;
  int bad = 0;
  int n;

  always #5 clk_pixel = ~clk_pixel;

  dram_request_arbiter dut (
    .clk_pixel(clk_pixel), .dram_arbiter_reset(rst), .dram_arbiter_flush(flush),
    .rd_req_en(rd_req_en), .rd_req_addr(rd_req_addr), .rd_req_len(rd_req_len),
    .rd_req_busy(rd_req_busy), .rd_data(rd_data), .rd_data_valid(rd_data_valid),
    .wr_req_en(wr_req_en), .wr_req_addr(wr_req_addr), .wr_req_len(wr_req_len),
    .wr_req_data(wr_req_data), .wr_req_busy(wr_req_busy),
    .dram_read_addr(dram_read_addr), .dram_read_len(dram_read_len), .dram_read_en(dram_read_en),
    .dram_read_busy(dram_read_busy), .dram_read_data(dram_read_data),
    .dram_read_data_valid(dram_read_data_valid),
    .dram_write_addr(dram_write_addr), .dram_write_len(dram_write_len),
    .dram_write_en(dram_write_en), .dram_write_data(dram_write_data),
    .dram_write_busy(dram_write_busy), .err_flags(err_flags)
  );

  task automatic step();
    @(posedge clk_pixel);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic pulse_rd(input int r, input logic [38:0] a, input logic [7:0] l);
    rd_req_addr[r*39 +: 39] = a;
    rd_req_len[r*8 +: 8]    = l;
    rd_req_en               = '0;
    rd_req_en[r]            = 1'b1;
    step();
    rd_req_en = '0;
  endtask

  task automatic wait_cmd(input logic [38:0] a, input logic [7:0] l, output int waited);
    waited = 0;
    while (!dram_read_en && waited < 12) begin
      step();
      waited++;
    end
    chk("cmd_seen", dram_read_en, 1'b1);
    chk("cmd_addr", dram_read_addr, a);
    chk("cmd_len", dram_read_len, l);
    step();
  endtask

  task automatic issue_rd(input int r, input logic [38:0] a, input logic [7:0] l);
    int w;
    pulse_rd(r, a, l);
    wait_cmd(a, l, w);
    chk("cmd_latency", w, 1);
  endtask

  task automatic beat(input logic [127:0] d, input logic [1:0] exp_own);
    dram_read_data_valid = 1'b1;
    dram_read_data       = d;
    step();
    dram_read_data_valid = 1'b0;
    chk("beat_owner", rd_data_valid, exp_own);
    if (exp_own != 2'b00) chk("beat_data", rd_data, d);
  endtask

  task automatic count_rd_en(input int cycles, output int cnt);
    cnt = 0;
    for (int i = 0; i < cycles; i++) begin
      step();
      if (dram_read_en) cnt++;
    end
  endtask

  initial begin
    step();
    chk("rst_busy", rd_req_busy, 2'b00);
    chk("rst_valid", rd_data_valid, 2'b00);
    chk("rst_rd_en", dram_read_en, 1'b0);
    chk("rst_wr_en", dram_write_en, 1'b0);
    chk("rst_err", err_flags, 2'b00);
    chk("rst_rd_addr", dram_read_addr, 39'h0);
    step();
    rst = 1'b0;

    // Contention: both readers at once, twice; pointer starts at reader 1 so order is 0,1,0,1.
    rd_req_addr = {39'h3000, 39'h2000};
    rd_req_len  = {8'd3, 8'd2};
    rd_req_en   = 2'b11;
    step();
    rd_req_en = 2'b00;
    chk("cont_busy", rd_req_busy, 2'b11);
    step();
    chk("cont_g0_en", dram_read_en, 1'b1);
    chk("cont_g0_addr", dram_read_addr, 39'h2000);
    chk("cont_g0_len", dram_read_len, 8'd2);
    step();
    chk("cont_hold_en", dram_read_en, 1'b0);
    chk("cont_busy1", rd_req_busy, 2'b10);
    step();
    chk("cont_idle_en", dram_read_en, 1'b0);
    step();
    chk("cont_g1_en", dram_read_en, 1'b1);
    chk("cont_g1_addr", dram_read_addr, 39'h3000);
    chk("cont_g1_len", dram_read_len, 8'd3);
    step();
    chk("cont_busy0", rd_req_busy, 2'b00);
    beat(128'h11, 2'b01);
    beat(128'h12, 2'b01);
    beat(128'h21, 2'b10);
    beat(128'h22, 2'b10);
    beat(128'h23, 2'b10);
    rd_req_addr = {39'h3100, 39'h2100};
    rd_req_len  = {8'd1, 8'd1};
    rd_req_en   = 2'b11;
    step();
    rd_req_en = 2'b00;
    step();
    chk("cont2_g0_addr", dram_read_addr, 39'h2100);
    step(); step(); step();
    chk("cont2_g1_addr", dram_read_addr, 39'h3100);
    step();
    beat(128'h31, 2'b01);
    beat(128'h41, 2'b10);

    // Single read, then a stray beat with nothing outstanding.
    pulse_rd(0, 39'h1000, 8'd4);
    chk("single_busy", rd_req_busy, 2'b01);
    chk("single_early_en", dram_read_en, 1'b0);
    step();
    chk("single_en", dram_read_en, 1'b1);
    chk("single_addr", dram_read_addr, 39'h1000);
    chk("single_len", dram_read_len, 8'd4);
    step();
    for (int k = 0; k < 4; k++) beat(128'hA0 + 128'(k), 2'b01);
    beat(128'hBAD, 2'b00);
    chk("orphan_err", err_flags, 2'b01);

    // Zero-length requests are ignored.
    pulse_rd(0, 39'h1234, 8'd0);
    chk("zero_rd_busy", rd_req_busy, 2'b00);
    wr_req_en = 1'b1; wr_req_len = 8'd0;
    step();
    wr_req_en = 1'b0;
    chk("zero_wr_busy", wr_req_busy, 1'b0);
    count_rd_en(4, n);
    chk("zero_no_cmd", n, 0);

    // Backpressure: nothing issues while the controller is busy.
    dram_read_busy = 1'b1;
    pulse_rd(1, 39'h5000, 8'd2);
    count_rd_en(20, n);
    chk("bp_no_cmd", n, 0);
    chk("bp_busy", rd_req_busy, 2'b10);
    dram_read_busy = 1'b0;
    step();
    chk("bp_en", dram_read_en, 1'b1);
    chk("bp_addr", dram_read_addr, 39'h5000);
    step();
    beat(128'h51, 2'b10);
    beat(128'h52, 2'b10);

    // Owner FIFO full: eight single-beat reads outstanding block the ninth.
    for (int k = 0; k < 8; k++) issue_rd(0, 39'h8000 + 39'(k * 16), 8'd1);
    pulse_rd(1, 39'h9000, 8'd1);
    count_rd_en(10, n);
    chk("full_no_cmd", n, 0);
    chk("full_busy", rd_req_busy, 2'b10);
    beat(128'h80, 2'b01);
    wait_cmd(39'h9000, 8'd1, n);
    for (int k = 1; k < 8; k++) beat(128'h80 + 128'(k), 2'b01);
    beat(128'h90, 2'b10);

    // Overrun: repeated pulses while pending are dropped and flagged.
    dram_read_busy = 1'b1;
    pulse_rd(0, 39'hA000, 8'd1);
    pulse_rd(0, 39'hA100, 8'd1);
    pulse_rd(0, 39'hA200, 8'd1);
    chk("ovr_err", err_flags, 2'b11);
    chk("ovr_busy", rd_req_busy, 2'b01);
    dram_read_busy = 1'b0;
    count_rd_en(8, n);
    chk("ovr_one_cmd", n, 1);
    chk("ovr_busy_clr", rd_req_busy, 2'b00);
    beat(128'hA0A0, 2'b01);

    // Read and write channels issue in the same cycle.
    rd_req_addr[39 +: 39] = 39'hE000;
    rd_req_len[8 +: 8]    = 8'd1;
    rd_req_en   = 2'b10;
    wr_req_en   = 1'b1;
    wr_req_addr = 39'hB000;
    wr_req_len  = 8'd5;
    wr_req_data = 128'hDEAD_BEEF;
    step();
    rd_req_en = 2'b00;
    wr_req_en = 1'b0;
    chk("rw_rd_busy", rd_req_busy, 2'b10);
    chk("rw_wr_busy", wr_req_busy, 1'b1);
    step();
    chk("rw_rd_en", dram_read_en, 1'b1);
    chk("rw_rd_addr", dram_read_addr, 39'hE000);
    chk("rw_wr_en", dram_write_en, 1'b1);
    chk("rw_wr_addr", dram_write_addr, 39'hB000);
    chk("rw_wr_len", dram_write_len, 8'd5);
    chk("rw_wr_data", dram_write_data, 128'hDEAD_BEEF);
    step();
    chk("rw_wr_en_off", dram_write_en, 1'b0);
    chk("rw_wr_busy_clr", wr_req_busy, 1'b0);
    beat(128'hE1, 2'b10);

    // Flush drops the pending request but the outstanding read still routes.
    issue_rd(0, 39'hC000, 8'd2);
    dram_read_busy = 1'b1;
    pulse_rd(1, 39'hC100, 8'd1);
    chk("fl_busy", rd_req_busy, 2'b10);
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("fl_cleared", rd_req_busy, 2'b00);
    dram_read_busy = 1'b0;
    count_rd_en(6, n);
    chk("fl_no_cmd", n, 0);
    beat(128'hC1, 2'b01);
    beat(128'hC2, 2'b01);

    // Reset in the middle of a burst.
    issue_rd(1, 39'hD000, 8'd3);
    beat(128'hD1, 2'b10);
    dram_read_busy = 1'b1;
    pulse_rd(0, 39'hD100, 8'd2);
    chk("mr_busy", rd_req_busy, 2'b01);
    beat(128'hD2, 2'b10);
    rst = 1'b1;
    #1;
    chk("mr_valid", rd_data_valid, 2'b00);
    chk("mr_data", rd_data, 128'h0);
    chk("mr_busy0", rd_req_busy, 2'b00);
    chk("mr_err", err_flags, 2'b00);
    chk("mr_rd_en", dram_read_en, 1'b0);
    chk("mr_wr_busy", wr_req_busy, 1'b0);
    step();
    rst = 1'b0;
    dram_read_busy = 1'b0;
    beat(128'hD3, 2'b00);
    chk("mr_orphan", err_flags, 2'b01);
    count_rd_en(5, n);
    chk("mr_no_cmd", n, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dram_request_arbiter.md
Name: dram_request_arbiter

Overview:
Shares one DRAM read command channel among NUM_READERS image-sender read requesters, using round-robin arbitration. Passes one DRAM write requester through to the DRAM write channel.
Records the owner of every issued read in an owner FIFO and steers returned read beats to that requester, in order.
Sits between the image sender and image loader blocks and the DRAM controller, in the clk_pixel domain.

Parameters:
NUM_READERS, 2, number of read requesters (2..4)
DRAM_ADDR_WIDTH, 39, DRAM byte address width
DRAM_DATA_WIDTH, 128, DRAM beat width
OWNER_FIFO_DEPTH, 8, maximum outstanding read commands (power of 2)

Ports:
clk_pixel  in  1  clock
dram_arbiter_reset  in  1  reset, asynchronous, active-high
dram_arbiter_flush  in  1  synchronous clear of pending requests
rd_req_en  in  NUM_READERS  per-reader request pulse
rd_req_addr  in  NUM_READERS*DRAM_ADDR_WIDTH  packed per-reader read address; reader i uses slice i
rd_req_len  in  NUM_READERS*8  packed per-reader beat count; reader i uses slice i
rd_req_busy  out  NUM_READERS  reader's request is pending
rd_data  out  DRAM_DATA_WIDTH  returned beat, registered
rd_data_valid  out  NUM_READERS  one-hot owner strobe for rd_data
wr_req_en  in  1  write request pulse
wr_req_addr  in  DRAM_ADDR_WIDTH  write address
wr_req_len  in  8  write length
wr_req_data  in  DRAM_DATA_WIDTH  write data
wr_req_busy  out  1  write request is pending
dram_read_addr  out  DRAM_ADDR_WIDTH  read command address
dram_read_len  out  8  read command length
dram_read_en  out  1  read command pulse
dram_read_busy  in  1  DRAM controller read channel busy
dram_read_data  in  DRAM_DATA_WIDTH  read beat
dram_read_data_valid  in  1  read beat valid
dram_write_addr  out  DRAM_ADDR_WIDTH  write command address
dram_write_len  out  8  write command length
dram_write_en  out  1  write command pulse
dram_write_data  out  DRAM_DATA_WIDTH  write command data
dram_write_busy  in  1  DRAM controller write channel busy
err_flags  out  2  sticky: bit0 orphan beat, bit1 request overrun

Behaviour:
- Reset: all outputs 0, pending registers cleared, owner FIFO emptied, beat counter 0, round-robin pointer = NUM_READERS-1, read and write FSMs in IDLE.
- Capture: rd_req_en[i] at edge t latches addr and len into pending slot i; rd_req_busy[i]=1 from t+1.
- Overrun: rd_req_en[i] while rd_req_busy[i]=1 is dropped and sets err_flags[1]. The same rule applies to wr_req_en while wr_req_busy=1.
- Zero length: a len=0 request is never captured; busy stays 0.
- Read FSM states: IDLE, ISSUE, HOLD.
  - IDLE -> ISSUE when any slot is pending, dram_read_busy=0 and the owner FIFO is not full. The grant goes to the first pending index after the pointer, circularly.
  - ISSUE: dram_read_en=1 for exactly one cycle, with the winner's addr and len. Push {index, len} to the owner FIFO. Clear the winner's pending bit and busy. Set pointer = winner. Go to HOLD.
  - HOLD: one cycle, so that dram_read_busy can rise. Then return to IDLE.
- Read latency: request edge t -> dram_read_en high in cycle t+2 at best. Back-to-back commands are at least 3 cycles apart.
- Return path: each dram_read_data_valid beat goes to rd_data, with rd_data_valid one-hot for the owner FIFO head index, one cycle later.
  - Beat counter increments per beat. At beat == head len, pop the FIFO and clear the counter.
  - A beat arriving with the FIFO empty is discarded and sets err_flags[0].
- Write FSM states: IDLE, ISSUE, HOLD. Same rules as the read FSM, gated by dram_write_busy. There is no write arbitration. Write latency is also t+2.
- Read and write channels are independent; both may issue in the same cycle.
- Flush: clears all pending slots and busy bits. Outstanding reads (already in the owner FIFO) still complete and route normally. When flush and a request land in the same cycle, flush wins.
- The owner FIFO push and pop may happen in the same cycle; occupancy is unchanged.
- Reset mid-burst: everything returns to reset values immediately; late beats after reset release count as orphans.
- err_flags clear only on reset.

Optional Feature:
DRAM_ARB_FIXED_PRIORITY_EN: when defined, the read grant is the lowest-index pending reader (reader 0 highest) and the pointer is unused. When undefined, round-robin applies as described above.

Test Plan:
- Single read: reader0 pulses addr=0x1000, len=4 -> dram_read_en 2 cycles later with addr 0x1000, len 4; 4 beats -> rd_data_valid=2'b01 four times; FIFO empty afterwards.
- Contention: readers 0 and 1 pulse in the same cycle, then both again after service -> grant order 0,1,0,1; returned beats carry the matching one-hot owner.
- Backpressure: hold dram_read_busy=1 for 20 cycles with reader1 pending -> no dram_read_en; command issues 1 cycle after busy falls.
- Owner FIFO full: issue 8 len=1 reads with no returned beats -> 9th stays pending, busy=1; one beat returns -> 9th issues.
- Errors: drive dram_read_data_valid with nothing outstanding -> err_flags=2'b01, beat discarded; pulse rd_req_en[0] twice while busy -> bit1 set, only one command issued.
- Flush and reset: flush with reader1 pending and one read outstanding -> pending cleared, outstanding beats still routed; assert reset mid-burst -> all outputs 0 immediately.
